// File: rtl/rd_burst_scheduler_if.sv
// Requester job port plus burst-command port shared between rd_burst_scheduler and its environment.
// The master modport is the scheduler side; slave is the requesters/read-master side.
interface rd_burst_scheduler_if #(
  parameter int P_REQ_NUM        = 2,
  parameter int P_AXI_ADDR_WIDTH = 32,
  parameter int P_LEN_WIDTH      = 24
);
  logic [P_REQ_NUM-1:0]                  i_req_valid;
  logic [P_REQ_NUM*P_AXI_ADDR_WIDTH-1:0] i_req_addr;
  logic [P_REQ_NUM*P_LEN_WIDTH-1:0]      i_req_bytes;
  logic [P_REQ_NUM-1:0]                  o_req_ready;
  logic [P_REQ_NUM-1:0]                  o_req_done;
  logic [1:0]                            o_grant_id;
  logic                                  o_busy;
  logic                                  o_cmd_rden;
  logic [P_AXI_ADDR_WIDTH-1:0]           o_cmd_addr;
  logic [7:0]                            o_cmd_length;
  logic                                  i_cmd_ready;
  logic                                  i_burst_last;

  modport master (
    input  i_req_valid, i_req_addr, i_req_bytes, i_cmd_ready, i_burst_last,
    output o_req_ready, o_req_done, o_grant_id, o_busy,
           o_cmd_rden, o_cmd_addr, o_cmd_length
  );

  modport slave (
    output i_req_valid, i_req_addr, i_req_bytes, i_cmd_ready, i_burst_last,
    input  o_req_ready, o_req_done, o_grant_id, o_busy,
           o_cmd_rden, o_cmd_addr, o_cmd_length
  );
endinterface

// File: rtl/rd_burst_scheduler.sv
// Round-robin read-job scheduler: splits each granted job into INCR bursts that stay inside
// a 4 KB page and under P_MAX_BEATS, issues them to the read master and tracks returned bursts.
module rd_burst_scheduler #(
  parameter int P_REQ_NUM        = 2,
  parameter int P_AXI_ADDR_WIDTH = 32,
  parameter int P_AXI_DATA_WIDTH = 128,
  parameter int P_LEN_WIDTH      = 24,
  parameter int P_MAX_BEATS      = 256
) (
  input logic                  i_axi_clk,
  input logic                  r_user_rst,
  rd_burst_scheduler_if.master bus
);
  localparam int BEAT_BYTES = P_AXI_DATA_WIDTH / 8;
  localparam int BEAT_SH    = $clog2(BEAT_BYTES);
  localparam int REM_W      = P_LEN_WIDTH - BEAT_SH;
  localparam int AW         = P_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_rr, r_grant;
  logic                 r_busy;
  logic [P_REQ_NUM-1:0] r_req_ready;
  logic [AW-1:0]        r_addr, r_cmd_addr;
  logic [REM_W-1:0]     r_beats_rem;
  logic [8:0]           r_burst;
  logic [7:0]           r_cmd_length;
  logic [8:0]           r_outst, w_outst_nxt;

  logic                 w_gnt_found, w_hi_found;
  logic [1:0]           w_gnt_idx, w_lo_idx, w_hi_idx, w_rr_nxt;
  logic [AW-1:0]        w_sel_addr;
  logic [P_LEN_WIDTH-1:0] w_sel_bytes;
  logic [REM_W-1:0]     w_sel_beats;
  logic [12:0]          w_to4k;
  logic [8:0]           w_burst;
  logic                 w_strobe;

  function automatic logic [8:0] f_burst_len(input logic [12:0] to4k, input logic [REM_W-1:0] rem);
    logic [31:0] m;
    m = 32'(to4k);
    if (32'(rem) < m)        m = 32'(rem);
    if (32'(P_MAX_BEATS) < m) m = 32'(P_MAX_BEATS);
    return m[8:0];
  endfunction

  // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    w_gnt_found = |bus.i_req_valid;
    w_lo_idx    = '0;
    w_hi_idx    = '0;
    w_hi_found  = 1'b0;
    for (int i = P_REQ_NUM - 1; i >= 0; i--) begin
      if (bus.i_req_valid[i]) w_lo_idx = 2'(i);
      if (bus.i_req_valid[i] && (2'(i) >= r_rr)) begin
        w_hi_idx   = 2'(i);
        w_hi_found = 1'b1;
      end
    end
    w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  assign w_rr_nxt    = (w_gnt_idx == 2'(P_REQ_NUM - 1)) ? 2'd0 : w_gnt_idx + 2'd1;
  assign w_sel_addr  = bus.i_req_addr[w_gnt_idx*AW +: AW];
  assign w_sel_bytes = bus.i_req_bytes[w_gnt_idx*P_LEN_WIDTH +: P_LEN_WIDTH];
  assign w_sel_beats = REM_W'(w_sel_bytes >> BEAT_SH);

  assign w_to4k   = (13'h1000 - {1'b0, r_addr[11:0]}) >> BEAT_SH;
  assign w_burst  = f_burst_len(w_to4k, r_beats_rem);
  assign w_strobe = (r_state == S_ISSUE) && bus.i_cmd_ready;

  // A last arriving with nothing outstanding (e.g. after a mid-job reset) is dropped.
  always_comb begin
    w_outst_nxt = r_outst;
    if (w_strobe && !bus.i_burst_last)
      w_outst_nxt = r_outst + 9'd1;
    else if (!w_strobe && bus.i_burst_last && (r_outst != 9'd0))
      w_outst_nxt = r_outst - 9'd1;
  end

  always_ff @(posedge i_axi_clk or posedge r_user_rst) begin
    if (r_user_rst) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // WAIT looks at the next outstanding count so done follows the final last by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_found) w_state_nxt = (w_sel_beats == '0) ? S_DONE : S_CALC;
      S_CALC:  w_state_nxt = S_ISSUE;
      S_ISSUE: if (bus.i_cmd_ready)
                 w_state_nxt = (r_beats_rem != REM_W'(r_burst)) ? S_CALC : S_WAIT;
      S_WAIT:  if (w_outst_nxt == 9'd0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk or posedge r_user_rst) begin
    if (r_user_rst) begin
      r_rr         <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_req_ready  <= '0;
      r_addr       <= '0;
      r_beats_rem  <= '0;
      r_burst      <= '0;
      r_cmd_addr   <= '0;
      r_cmd_length <= '0;
      r_outst      <= '0;
    end else begin
      r_req_ready <= '0;
      r_outst     <= w_outst_nxt;
      case (r_state)
        S_IDLE: if (w_gnt_found) begin
          r_req_ready <= P_REQ_NUM'(1) << w_gnt_idx;
          r_grant     <= w_gnt_idx;
          r_busy      <= 1'b1;
          r_rr        <= w_rr_nxt;
          r_addr      <= w_sel_addr & ~AW'(BEAT_BYTES - 1);
          r_beats_rem <= w_sel_beats;
        end
        S_CALC: r_burst <= w_burst;
        S_ISSUE: if (w_strobe) begin
          r_addr       <= r_addr + (AW'(r_burst) << BEAT_SH);
          r_beats_rem  <= r_beats_rem - REM_W'(r_burst);
          r_cmd_addr   <= r_addr;
          r_cmd_length <= 8'(r_burst - 9'd1);
        end
        S_DONE: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Strobe goes out in the same cycle the master is ready; the bus then holds the last command.
  assign bus.o_cmd_rden   = w_strobe;
  assign bus.o_cmd_addr   = w_strobe ? r_addr : r_cmd_addr;
  assign bus.o_cmd_length = w_strobe ? 8'(r_burst - 9'd1) : r_cmd_length;
  assign bus.o_req_ready  = r_req_ready;
  assign bus.o_req_done   = (r_state == S_DONE) ? (P_REQ_NUM'(1) << r_grant) : '0;
  assign bus.o_grant_id   = r_grant;
  assign bus.o_busy       = r_busy;
endmodule
